// File: rtl/accel_program_loader.sv
// accel_program_loader: turns a framed host byte stream into instruction-store
// and data-memory write strobes, and launches the accelerator.
// Frame: header {cmd[7:6], x, base[4:0]}, length N, then N words LSB-first.
// Optional: define LOADER_CHECKSUM_EN for a trailing XOR checksum byte per
// LOAD frame, reported through csum_err / csum_err_sticky.
module accel_program_loader #(
  parameter int NUM_SIZE         = 16,
  parameter int NUM_INSTRUCTIONS = 16,
  parameter int WORDS_IN_MEMORY  = 32,
  parameter int INSTR_WIDTH      = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [7:0]                          s_data,
  output logic                                instr_we,
  output logic [$clog2(NUM_INSTRUCTIONS)-1:0] instr_addr,
  output logic [INSTR_WIDTH-1:0]              instr_wdata,
  output logic                                mem_we,
  output logic [$clog2(WORDS_IN_MEMORY)-1:0]  mem_addr,
  output logic [NUM_SIZE-1:0]                 mem_wdata,
  output logic                                start,
  input  logic                                accel_halted,
  output logic                                busy
`ifdef LOADER_CHECKSUM_EN
  , output logic                              csum_err,
  output logic                                csum_err_sticky
`endif
);

  localparam int IAW  = $clog2(NUM_INSTRUCTIONS);
  localparam int DAW  = $clog2(WORDS_IN_MEMORY);
  localparam int IB   = INSTR_WIDTH / 8;
  localparam int DB   = NUM_SIZE / 8;
  localparam int MAXB = (IB > DB) ? IB : DB;
  localparam int SW   = MAXB * 8;
  localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam logic [BW-1:0]  ILAST = BW'(IB - 1);
  localparam logic [BW-1:0]  DLAST = BW'(DB - 1);
  localparam logic [IAW-1:0] ITOP  = IAW'(NUM_INSTRUCTIONS - 1);
  localparam logic [DAW-1:0] DTOP  = DAW'(WORDS_IN_MEMORY - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, START, RUN, CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, START, RUN} state_t;
`endif

  state_t             state_q;
  logic               s_ready_q, busy_q, start_q;
  logic               instr_we_q, mem_we_q, is_instr_q;
  logic [IAW-1:0]     instr_addr_q;
  logic [DAW-1:0]     mem_addr_q;
  logic [INSTR_WIDTH-1:0] instr_wdata_q;
  logic [NUM_SIZE-1:0]    mem_wdata_q;
  logic [BW-1:0]      bcnt_q;
  logic [7:0]         n_q, wcnt_q;
  logic [SW-1:0]      sh_q, word_d;
  logic               accept, last_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum_q;
  logic               csum_err_q, csum_err_sticky_q;
`endif

  assign accept    = s_valid & s_ready_q;
  assign last_byte = (bcnt_q == (is_instr_q ? ILAST : DLAST));

  // Word as it will look once the byte on s_data is merged in.
  always_comb begin
    word_d = sh_q;
    word_d[bcnt_q*8 +: 8] = s_data;
  end

  // Frame decoder FSM; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      s_ready_q     <= 1'b1;
      busy_q        <= 1'b0;
      start_q       <= 1'b0;
      instr_we_q    <= 1'b0;
      mem_we_q      <= 1'b0;
      is_instr_q    <= 1'b0;
      instr_addr_q  <= '0;
      mem_addr_q    <= '0;
      instr_wdata_q <= '0;
      mem_wdata_q   <= '0;
      bcnt_q        <= '0;
      n_q           <= '0;
      wcnt_q        <= '0;
      sh_q          <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q            <= '0;
      csum_err_q        <= 1'b0;
      csum_err_sticky_q <= 1'b0;
`endif
    end else begin
      instr_we_q <= 1'b0;
      mem_we_q   <= 1'b0;
      start_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_err_q <= 1'b0;
`endif
      // Address advances in the write cycle; a header latched in the same
      // cycle overrides it (assigned later below).
      if (instr_we_q) instr_addr_q <= (instr_addr_q == ITOP) ? '0 : instr_addr_q + 1'b1;
      if (mem_we_q)   mem_addr_q   <= (mem_addr_q == DTOP) ? '0 : mem_addr_q + 1'b1;

      case (state_q)
        IDLE: if (accept) begin
          case (s_data[7:6])
            2'b00, 2'b01: begin
              is_instr_q <= ~s_data[6];
              if (s_data[6]) mem_addr_q   <= DAW'(s_data[4:0]);
              else           instr_addr_q <= IAW'(s_data[4:0]);
              state_q <= LEN;
              busy_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
              csum_q  <= s_data;
`endif
            end
            2'b10: begin
              state_q   <= START;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b1;
              start_q   <= 1'b1;
            end
            default: ;  // reserved command byte is dropped
          endcase
        end
        LEN: if (accept) begin
          n_q    <= s_data;
          wcnt_q <= '0;
          bcnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
          csum_q <= csum_q ^ s_data;
          state_q <= (s_data == 8'd0) ? CHK : PAYLOAD;
`else
          if (s_data == 8'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= PAYLOAD;
          end
`endif
        end
        PAYLOAD: if (accept) begin
          sh_q <= word_d;
`ifdef LOADER_CHECKSUM_EN
          csum_q <= csum_q ^ s_data;
`endif
          if (last_byte) begin
            bcnt_q <= '0;
            wcnt_q <= wcnt_q + 8'd1;
            if (is_instr_q) begin
              instr_we_q    <= 1'b1;
              instr_wdata_q <= word_d[INSTR_WIDTH-1:0];
            end else begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= word_d[NUM_SIZE-1:0];
            end
            if (wcnt_q == n_q - 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= CHK;
`else
              state_q <= IDLE;
              busy_q  <= 1'b0;
`endif
            end
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
        START: state_q <= RUN;
        RUN: if (accel_halted) begin
          state_q   <= IDLE;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b0;
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: if (accept) begin
          if (s_data != csum_q) begin
            csum_err_q        <= 1'b1;
            csum_err_sticky_q <= 1'b1;
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
`endif
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign busy        = busy_q;
  assign start       = start_q;
  assign instr_we    = instr_we_q;
  assign instr_addr  = instr_addr_q;
  assign instr_wdata = instr_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
  assign csum_err        = csum_err_q;
  assign csum_err_sticky = csum_err_sticky_q;
`endif

endmodule

// File: tb/tb_accel_program_loader.sv
// Scoreboard bench for accel_program_loader: stimulus pushes expected write /
// start events into a queue, a negedge monitor pops and compares them.
module tb_accel_program_loader;

  logic        clk = 1'b0, rst = 1'b1;
  logic        s_valid = 1'b0, s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        instr_we, mem_we, start, accel_halted = 1'b0, busy;
  logic [3:0]  instr_addr;
  logic [31:0] instr_wdata;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
`ifdef LOADER_CHECKSUM_EN
  logic        csum_err, csum_err_sticky;
  int          got_cerr = 0, exp_cerr = 0;
`endif

  accel_program_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .instr_we(instr_we), .instr_addr(instr_addr), .instr_wdata(instr_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .start(start), .accel_halted(accel_halted), .busy(busy)
`ifdef LOADER_CHECKSUM_EN
    , .csum_err(csum_err), .csum_err_sticky(csum_err_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int addr; longint unsigned data; } ev_t;  // 0 instr, 1 mem, 2 start
  ev_t exp_q[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_ev(input int kind, input int addr, input longint unsigned data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event kind %0d addr %0d data %0h", kind, addr, data);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", longint'(kind), longint'(e.kind));
      chk("ev_addr", longint'(addr), longint'(e.addr));
      chk("ev_data", data, e.data);
    end
  endtask

  // Monitor: every strobe/start pulse must match the next expected event.
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_we || mem_we) begin
        chk("we_exclusive", longint'(instr_we & mem_we), 0);
        chk("we_outside_run", longint'(s_ready), 1);
      end
      if (instr_we) pop_ev(0, int'(instr_addr), longint'(instr_wdata));
      if (mem_we)   pop_ev(1, int'(mem_addr), longint'(mem_wdata));
      if (start) begin
        chk("start_ready", longint'(s_ready), 0);
        pop_ev(2, 0, 0);
      end
`ifdef LOADER_CHECKSUM_EN
      if (csum_err) got_cerr++;
`endif
    end
  end

  // Drive one byte, waiting (bounded) for s_ready; returns on a negedge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 1, 0);
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Send a LOAD frame's bytes; the checksum byte is appended when enabled.
  task automatic send_frame(input logic [7:0] bytes[$], input bit bad);
    logic [7:0] x = 8'h00;
    foreach (bytes[i]) begin
      x ^= bytes[i];
      send(bytes[i]);
      gap();
    end
`ifdef LOADER_CHECKSUM_EN
    if (bad) exp_cerr++;
    send(x ^ {7'd0, bad});
`else
    if (bad) chk("bad_csum_without_feature", 1, 0);
`endif
    chk("busy_after_frame", longint'(busy), 0);
  endtask

  // Reference model: word i lands at (base + i) mod depth.
  task automatic load_frame(input bit instr, input int base, input int n, input bit bad);
    logic [7:0]  bytes[$];
    logic [31:0] w;
    ev_t e;
    int nb = instr ? 4 : 2;
    int depth = instr ? 16 : 32;
    bytes.push_back((instr ? 8'h00 : 8'h40) | 8'($urandom_range(0, 1) << 5) | 8'(base & 31));
    bytes.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (!instr) w = w & 32'hFFFF;
      e.kind = instr ? 0 : 1;
      e.addr = ((base & 31) + i) % depth;
      e.data = longint'(w);
      exp_q.push_back(e);
      for (int k = 0; k < nb; k++) bytes.push_back(w[8*k +: 8]);
    end
    send_frame(bytes, bad);
  endtask

  task automatic do_start(input int hold, input bit keep_valid);
    ev_t e;
    e.kind = 2; e.addr = 0; e.data = 0;
    exp_q.push_back(e);
    send(8'h80);
    s_valid = keep_valid;
    s_data  = 8'h55;
    for (int i = 0; i < hold; i++) begin
      chk("ready_in_run", longint'(s_ready), 0);
      @(negedge clk);
    end
    s_valid = 1'b0;
    accel_halted = 1'b1;
    @(negedge clk);
    accel_halted = 1'b0;
    chk("ready_after_halt", longint'(s_ready), 1);
    chk("busy_after_halt", longint'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fb[$];
    ev_t e;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_s_ready", longint'(s_ready), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_start", longint'(start), 0);
    chk("rst_we", longint'({instr_we, mem_we}), 0);
    chk("rst_addr", longint'({instr_addr, mem_addr}), 0);
    chk("rst_wdata", longint'({instr_wdata, mem_wdata}), 0);

    // LOAD_DATA at 0: 0x1234, 0xABCD.
    e.kind = 1; e.addr = 0; e.data = 64'h1234; exp_q.push_back(e);
    e.addr = 1; e.data = 64'hABCD; exp_q.push_back(e);
    fb = '{8'h40, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
    send_frame(fb, 1'b0);

    // LOAD_INSTR at 15 wraps to 0.
    e.kind = 0; e.addr = 15; e.data = 64'h00040000; exp_q.push_back(e);
    e.addr = 0; e.data = 64'h00280000; exp_q.push_back(e);
    fb = '{8'h0F, 8'h02, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h28, 8'h00};
    send_frame(fb, 1'b0);

    // START with host pushing bytes during RUN for 50 cycles.
    do_start(50, 1'b1);

    // Zero-length frame, then start.
    fb = '{8'h41, 8'h00};
    send_frame(fb, 1'b0);
    do_start(3, 1'b0);

    // Reset after 3 of 4 instruction bytes abandons the word.
    send(8'h00); send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("busy_after_midrst", longint'(busy), 0);
    load_frame(1'b1, 7, 1, 1'b0);

    // Randomized mix of frames.
    for (int t = 0; t < 40; t++) begin
      int sel = $urandom_range(0, 9);
      int n = ($urandom_range(0, 4) == 0) ? $urandom_range(15, 34) : $urandom_range(0, 5);
      if (sel < 4)       load_frame(1'b1, $urandom_range(0, 31), n, 1'b0);
      else if (sel < 8)  load_frame(1'b0, $urandom_range(0, 31), n, 1'b0);
      else if (sel == 8) do_start($urandom_range(1, 6), 1'($urandom_range(0, 1)));
      else begin
        send(8'hC0 | 8'($urandom_range(0, 63)));
        chk("busy_after_reserved", longint'(busy), 0);
      end
      gap();
    end

`ifdef LOADER_CHECKSUM_EN
    chk("sticky_clean", longint'(csum_err_sticky), 0);
    e.kind = 1; e.addr = 0; e.data = 64'h0001; exp_q.push_back(e);
    fb = '{8'h40, 8'h01, 8'h01, 8'h00};
    send_frame(fb, 1'b0);
    chk("sticky_after_good", longint'(csum_err_sticky), 0);
    exp_q.push_back(e);
    send_frame(fb, 1'b1);
    @(negedge clk);
    chk("sticky_after_bad", longint'(csum_err_sticky), 1);
    load_frame(1'b0, 3, 2, 1'b0);
    chk("sticky_holds", longint'(csum_err_sticky), 1);
`endif

    repeat (5) @(negedge clk);
    chk("events_drained", longint'(exp_q.size()), 0);
`ifdef LOADER_CHECKSUM_EN
    chk("csum_err_pulses", longint'(got_cerr), longint'(exp_cerr));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_program_loader.md
Name: accel_program_loader

Overview:
- Host-side writer that fills the accelerator's instruction store and data memory from a byte stream, then launches execution.
- Sits between a host byte link (UART or test bench) and the accelerator's instruction and memory write ports.
- Decodes framed load and start commands and emits word-wide write strobes.
- Holds off the host while the accelerator runs, until the accelerator reports halted.

Parameters:
NUM_SIZE, 16, data memory word width in bits (must be a multiple of 8)
NUM_INSTRUCTIONS, 16, instruction store depth
WORDS_IN_MEMORY, 32, data memory depth
INSTR_WIDTH, 32, instruction word width in bits (must be a multiple of 8)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  host byte valid
s_ready  out  1  loader can accept a byte
s_data  in  8  host byte
instr_we  out  1  instruction write strobe, one cycle
instr_addr  out  clog2(NUM_INSTRUCTIONS)  instruction write address
instr_wdata  out  INSTR_WIDTH  instruction write data
mem_we  out  1  data memory write strobe, one cycle
mem_addr  out  clog2(WORDS_IN_MEMORY)  data write address
mem_wdata  out  NUM_SIZE  data write data
start  out  1  one-cycle launch pulse to the accelerator
accel_halted  in  1  accelerator has executed HALT
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - On reset: state=IDLE; s_ready=1; instr_we, mem_we, start, busy = 0; addresses, wdata, byte counter and word counter = 0.
  - Reset mid-frame abandons the frame with no further writes.
- Handshake:
  - A byte is accepted on a cycle where s_valid and s_ready are both 1.
  - s_data is ignored when s_valid=0.
- Frame header byte (accepted in IDLE):
  - [7:6] cmd: 00 = LOAD_INSTR, 01 = LOAD_DATA, 10 = START, 11 = reserved.
  - [5] is ignored.
  - [4:0] is the base address. It is truncated to the target address width, so LOAD_INSTR uses [3:0].
- States:
  - IDLE: s_ready=1. On accept:
    - cmd 00 or 01: latch cmd and base address, go to LEN.
    - cmd 10: go to START.
    - cmd 11: drop the byte, stay in IDLE.
  - LEN: s_ready=1. Accepted byte is the word count N (0..255).
    - N=0: return to IDLE, no writes.
    - Otherwise: go to PAYLOAD.
  - PAYLOAD: s_ready=1. Bytes arrive least-significant byte first into a shift register.
    - Bytes per word: INSTR_WIDTH/8 (4) for LOAD_INSTR, NUM_SIZE/8 (2) for LOAD_DATA.
    - On the cycle the last byte of a word is accepted, the word is registered. On the next cycle, instr_we or mem_we is 1 for exactly one cycle, with the current address and the assembled word.
    - Then the address increments modulo the target depth: wrap-around is silent, e.g. instruction address 15 goes to 0.
    - After word N: return to IDLE.
    - The write cycle overlaps acceptance of the next byte, so there is no stall. Back-to-back writes are possible only for 1-byte words.
  - START: s_ready=0. start=1 for exactly this one cycle, then go to RUN.
  - RUN: s_ready=0. Stay until accel_halted=1 is sampled, then go to IDLE.
    - accel_halted is not sampled in the START cycle.
    - accel_halted already 1 on the first RUN cycle returns to IDLE on the next cycle.
- Write strobes:
  - instr_we and mem_we are never both 1 in the same cycle.
  - No write strobe is ever asserted in START or RUN.
- Timing: the loader is full duplex on the byte side. There is no backpressure except in START and RUN.
- Pause: s_valid low mid-frame pauses with state held indefinitely. There is no timeout.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - LOAD frames carry one extra trailing byte after the payload: the XOR of header, length and all payload bytes.
  - The loader sits in a CHK state (s_ready=1) for that byte.
  - On mismatch, an extra output port csum_err pulses high for one cycle and a sticky bit csum_err_sticky (extra output) sets. The sticky bit clears only on rst.
  - Writes already issued are not undone.
  - N=0 frames also carry the checksum byte.
- Not defined: no CHK state, no csum ports, frames end after the payload.

Test Plan:
- Reset then LOAD_DATA: bytes 0x40, 0x02, 0x34, 0x12, 0xCD, 0xAB -> mem_we pulses twice: addr 0 data 0x1234, then addr 1 data 0xABCD; busy=0 after.
- LOAD_INSTR header 0x0F, N=2, payload 0x00040000, 0x00280000 (LSB first) -> writes at instr_addr 15 then 0 (wrap); mem_we never 1.
- START byte 0x80 with accel_halted=0 -> start high exactly 1 cycle, s_ready=0; hold accel_halted=0 for 50 cycles with s_valid=1 -> no byte accepted; raise accel_halted -> s_ready=1 on the following cycle.
- Length 0 frame 0x41, 0x00, then 0x80 -> no writes, then start pulse.
- Reset asserted after 3 of 4 instruction bytes -> no instr_we; the next frame loads from its own base address correctly.
- With LOADER_CHECKSUM_EN: frame 0x40, 0x01, 0x01, 0x00, checksum 0x40 -> one mem_we, csum_err stays 0; same frame with checksum 0x41 -> csum_err pulses once and csum_err_sticky=1.
